// File: rtl/seq_det_pkg.sv
// Shared definitions for the two-source sequence detector arbiter.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN0 = 2'd1,
    RUN1 = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_PATTERN = 32'h43444143;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/seq_det_core.sv
// Byte-stream pattern detector: a 32-bit window that shifts one byte in at the
// LSB per accepted byte, with a match flag that follows the accepting cycle.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter logic [31:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       shift_en_i,
  input  logic [7:0] byte_i,
  output logic       match_o
);

  logic [31:0] window_q, window_d;
  logic        armed_q;

  // Next window: cleared when a new frame is granted, otherwise shift in the accepted byte.
  always_comb begin
    window_d = window_q;
    if (clear_i) begin
      window_d = '0;
    end else if (shift_en_i) begin
      window_d = {window_q[23:0], byte_i};
    end
  end

  // Window register plus a flag remembering that the previous cycle shifted a byte in.
  always_ff @(posedge clk) begin
    if (rst) begin
      window_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      armed_q  <= shift_en_i;
    end
  end

  // Both terms are flops, so the pulse lands the cycle after the completing byte is accepted.
  assign match_o = armed_q && (window_q == PATTERN);

endmodule

// File: rtl/seq_det_arbiter.sv
// Round-robin frame arbiter sharing one sequence detector between two byte sources.
// Optional per-source saturating match counters are built when MATCH_CNT_EN is defined.
module seq_det_arbiter
  import seq_det_pkg::*;
#(
  parameter logic [31:0] PATTERN = DEFAULT_PATTERN
`ifdef MATCH_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       busy,
  output logic       match,
  output logic       match_src
`ifdef MATCH_CNT_EN
  , output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       src_q;
  logic       accept;
  logic       owner;
  logic [7:0] byteSel;
  logic       clear;

  // Grant selection in IDLE and end-of-frame detection while a source owns the detector.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    clear   = 1'b0;
    accept  = 1'b0;
    owner   = SRC0;
    byteSel = s0_data;
    unique case (state_q)
      IDLE: begin
        if (s0_valid && s1_valid) begin
          state_d = (last_q == SRC0) ? RUN1 : RUN0;
        end else if (s0_valid) begin
          state_d = RUN0;
        end else if (s1_valid) begin
          state_d = RUN1;
        end
        clear = (state_d != IDLE);
      end
      RUN0: begin
        accept = s0_valid;
        if (s0_valid && s0_last) begin
          state_d = IDLE;
          last_d  = SRC0;
        end
      end
      RUN1: begin
        owner   = SRC1;
        byteSel = s1_data;
        accept  = s1_valid;
        if (s1_valid && s1_last) begin
          state_d = IDLE;
          last_d  = SRC1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, last-served source (reset to source 1 so source 0 wins the first tie) and match tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SRC1;
      src_q   <= SRC0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (accept) begin
        src_q <= owner;
      end
    end
  end

  assign s0_ready  = (state_q == RUN0);
  assign s1_ready  = (state_q == RUN1);
  assign busy      = (state_q != IDLE);
  assign match_src = src_q;

  seq_det_core #(
    .PATTERN(PATTERN)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .shift_en_i(accept),
    .byte_i    (byteSel),
    .match_o   (match)
  );

`ifdef MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Count matches per source, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (match) begin
      if (src_q == SRC0 && cnt0_q != '1) begin
        cnt0_q <= cnt0_q + CNT_ONE;
      end
      if (src_q == SRC1 && cnt1_q != '1) begin
        cnt1_q <= cnt1_q + CNT_ONE;
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Testbench for seq_det_arbiter: frame-level behavioural model plus directed and random scenarios.
module tb_seq_det_arbiter;

  localparam logic [31:0] PAT = 32'h43444143;
`ifdef MATCH_CNT_EN
  localparam int CW     = 2;
  localparam int CNTMAX = 3;
`else
  localparam int CNTMAX = 65535;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready, busy, match, match_src;
`ifdef MATCH_CNT_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        b;
    logic        m;
    logic        ms;
    logic [15:0] c0;
    logic [15:0] c1;
  } snap_t;

  snap_t      obsQ[$];
  snap_t      expQ[$];
  logic [8:0] f0[$];
  logic [8:0] f1[$];

  // Reference model state: owner -1 means nobody holds the grant.
  int         mOwner;
  int         mLastSrc;
  logic [7:0] mHist[$];
  bit         mPend;
  int         mPendSrc;
  int         mCnt[2];
  bit         mAcc0, mAcc1;

  always #5 clk = ~clk;

  seq_det_arbiter #(
    .PATTERN(PAT)
`ifdef MATCH_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_data  (s0_data),
    .s0_valid (s0_valid),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_data  (s1_data),
    .s1_valid (s1_valid),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .busy     (busy),
    .match    (match),
    .match_src(match_src)
`ifdef MATCH_CNT_EN
    , .cnt0   (cnt0),
    .cnt1     (cnt1)
`endif
  );

  // Advance the model by one clock edge using the inputs the DUT sampled.
  task automatic modelStep();
    bit         newMatch = 0;
    int         newSrc = 0;
    bit         v, l;
    logic [7:0] d;
    logic [31:0] w;
    int         n;
    mAcc0 = 0;
    mAcc1 = 0;
    if (rst) begin
      mOwner = -1; mLastSrc = 1; mHist.delete();
      mPend = 0; mPendSrc = 0; mCnt[0] = 0; mCnt[1] = 0;
      return;
    end
    if (mPend && mCnt[mPendSrc] < CNTMAX) mCnt[mPendSrc]++;
    if (mOwner == -1) begin
      if (s0_valid && s1_valid) mOwner = (mLastSrc == 0) ? 1 : 0;
      else if (s0_valid) mOwner = 0;
      else if (s1_valid) mOwner = 1;
      if (mOwner != -1) mHist.delete();
    end else begin
      v = (mOwner == 0) ? s0_valid : s1_valid;
      l = (mOwner == 0) ? s0_last : s1_last;
      d = (mOwner == 0) ? s0_data : s1_data;
      if (v) begin
        mHist.push_back(d);
        if (mOwner == 0) mAcc0 = 1; else mAcc1 = 1;
        n = mHist.size();
        if (n >= 4) begin
          w = {mHist[n-4], mHist[n-3], mHist[n-2], mHist[n-1]};
          if (w == PAT) begin newMatch = 1; newSrc = mOwner; end
        end
        if (l) begin mLastSrc = mOwner; mOwner = -1; end
      end
    end
    mPend = newMatch;
    if (newMatch) mPendSrc = newSrc;
  endtask

  // One clock: update model at the edge, then record DUT and model views 1 time unit later.
  task automatic tick();
    snap_t o, e;
    @(posedge clk);
    modelStep();
    #1;
    o = '0; e = '0;
    o.r0 = s0_ready; o.r1 = s1_ready; o.b = busy; o.m = match;
    o.ms = match ? match_src : 1'b0;
    e.r0 = (mOwner == 0); e.r1 = (mOwner == 1); e.b = (mOwner != -1); e.m = mPend;
    e.ms = mPend ? 1'(mPendSrc) : 1'b0;
`ifdef MATCH_CNT_EN
    o.c0 = 16'(cnt0); o.c1 = 16'(cnt1);
    e.c0 = 16'(mCnt[0]); e.c1 = 16'(mCnt[1]);
`endif
    obsQ.push_back(o);
    expQ.push_back(e);
  endtask

  task automatic applyReset();
    rst = 1'b1; s0_valid = 0; s1_valid = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Present queued frames from both sources until drained or the cycle budget runs out.
  task automatic applyStimulus(input int maxCycles, input bit gaps, output bit drained);
    obsQ.delete(); expQ.delete();
    for (int c = 0; c < maxCycles && (f0.size() > 0 || f1.size() > 0); c++) begin
      s0_valid = (f0.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
      s1_valid = (f1.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
      {s0_last, s0_data} = (f0.size() > 0) ? f0[0] : 9'h0;
      {s1_last, s1_data} = (f1.size() > 0) ? f1[0] : 9'h0;
      tick();
      if (mAcc0) void'(f0.pop_front());
      if (mAcc1) void'(f1.pop_front());
    end
    drained = (f0.size() == 0 && f1.size() == 0);
    s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
    tick(); tick();
  endtask

  task automatic pushStr(input int src, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (src == 0) f0.push_back({(i == s.len() - 1), s[i]});
      else          f1.push_back({(i == s.len() - 1), s[i]});
    end
  endtask

  task automatic test_reset();
    snap_t zero = '0;
    applyReset();
    checks++;
    if (obsQ[obsQ.size()-1] !== zero) begin
      errors++; $display("[TB] FAIL reset.outputs got=%h exp=%h", obsQ[obsQ.size()-1], zero);
    end
  endtask

  task automatic test_single_frame();
    bit dr;
    int nm = 0;
    pushStr(0, "CDAC");
    applyStimulus(50, 0, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL single.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
      nm += int'(obsQ[i].m);
    end
    checks++;
    if (!(obsQ[4].m === 1'b1 && obsQ[4].ms === 1'b0 && obsQ[4].b === 1'b0 && nm == 1)) begin
      errors++; $display("[TB] FAIL single.match_at_4 got m=%b src=%b busy=%b count=%0d exp m=1 src=0 busy=0 count=1", obsQ[4].m, obsQ[4].ms, obsQ[4].b, nm);
    end
  endtask

  task automatic test_overlap();
    bit dr;
    int idx[$];
    pushStr(0, "CDACDAC");
    applyStimulus(50, 0, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL overlap.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
      if (obsQ[i].m) idx.push_back(i);
    end
    checks++;
    if (!(idx.size() == 2 && idx[0] == 4 && idx[1] == 7)) begin
      errors++; $display("[TB] FAIL overlap.positions got=%p exp='{4,7}", idx);
    end
  endtask

  task automatic test_round_robin();
    bit dr;
    applyReset();
    pushStr(0, "AB"); pushStr(0, "EF"); pushStr(1, "XY");
    applyStimulus(50, 0, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rr.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
    end
    checks++;
    if (!(obsQ[0].r0 === 1 && obsQ[1].r1 === 0 && obsQ[2].b === 0 && obsQ[3].r1 === 1 &&
          obsQ[5].b === 0 && obsQ[6].r0 === 1)) begin
      errors++; $display("[TB] FAIL rr.order got r0@0=%b r1@1=%b busy@2=%b r1@3=%b busy@5=%b r0@6=%b exp 1 0 0 1 0 1",
                         obsQ[0].r0, obsQ[1].r1, obsQ[2].b, obsQ[3].r1, obsQ[5].b, obsQ[6].r0);
    end
  endtask

  task automatic test_cross_frame();
    bit dr;
    int nm = 0;
    applyReset();
    pushStr(0, "CD"); pushStr(1, "AC");
    applyStimulus(50, 0, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL cross.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
      nm += int'(obsQ[i].m);
    end
    checks++;
    if (nm != 0 || !dr) begin errors++; $display("[TB] FAIL cross.no_match got count=%0d drained=%0d exp count=0 drained=1", nm, dr); end
  endtask

  task automatic test_reset_midframe();
    bit dr;
    pushStr(0, "CDAC");
    applyStimulus(3, 0, dr);
    s0_valid = 1; {s0_last, s0_data} = f0[0];
    rst = 1'b1;
    tick();
    checks++;
    if ({s0_ready, s1_ready, busy, match} !== 4'b0000) begin
      errors++; $display("[TB] FAIL midrst.outputs got=%b exp=0000", {s0_ready, s1_ready, busy, match});
    end
    rst = 1'b0; s0_valid = 0; f0.delete();
    pushStr(1, "CDAC");
    applyStimulus(50, 0, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL midrst.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
    end
    checks++;
    if (!(obsQ[4].m === 1'b1 && obsQ[4].ms === 1'b1)) begin
      errors++; $display("[TB] FAIL midrst.match got m=%b src=%b exp m=1 src=1", obsQ[4].m, obsQ[4].ms);
    end
  endtask

`ifdef MATCH_CNT_EN
  task automatic test_counters();
    bit dr;
    int expC[5] = '{1, 2, 3, 3, 3};
    applyReset();
    for (int k = 0; k < 5; k++) begin
      pushStr(1, "CDAC");
      applyStimulus(50, 0, dr);
      checks++;
      if (cnt1 !== 2'(expC[k]) || cnt0 !== 2'd0) begin
        errors++; $display("[TB] FAIL cnt.frame%0d got cnt1=%0d cnt0=%0d exp cnt1=%0d cnt0=0", k, cnt1, cnt0, expC[k]);
      end
    end
  endtask
`endif

  task automatic test_random();
    bit         dr;
    int         expM[2] = '{0, 0};
    int         gotM[2] = '{0, 0};
    logic [7:0] alpha[4] = '{8'h43, 8'h44, 8'h41, 8'h58};
    logic [31:0] p = PAT;
    logic [7:0] fr[$];
    int         len, k, n;
    for (int src = 0; src < 2; src++) begin
      for (int f = 0; f < 20; f++) begin
        fr.delete();
        len = $urandom_range(1, 9);
        for (int i = 0; i < len; i++) fr.push_back(alpha[$urandom_range(0, 3)]);
        if (len >= 4 && $urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, len - 4);
          fr[k] = p[31:24]; fr[k+1] = p[23:16]; fr[k+2] = p[15:8]; fr[k+3] = p[7:0];
        end
        n = fr.size();
        for (int i = 3; i < n; i++)
          if ({fr[i-3], fr[i-2], fr[i-1], fr[i]} == p) expM[src]++;
        for (int i = 0; i < n; i++) begin
          if (src == 0) f0.push_back({(i == n - 1), fr[i]});
          else          f1.push_back({(i == n - 1), fr[i]});
        end
      end
    end
    applyStimulus(4000, 1, dr);
    for (int i = 0; i < obsQ.size(); i++) begin
      checks++;
      if (obsQ[i] !== expQ[i]) begin errors++; $display("[TB] FAIL random.cycle%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
      if (obsQ[i].m) gotM[obsQ[i].ms]++;
    end
    checks++;
    if (!dr || gotM[0] != expM[0] || gotM[1] != expM[1]) begin
      errors++; $display("[TB] FAIL random.totals got drained=%0d m0=%0d m1=%0d exp drained=1 m0=%0d m1=%0d", dr, gotM[0], gotM[1], expM[0], expM[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overlap();
    test_round_robin();
    test_cross_frame();
    test_reset_midframe();
`ifdef MATCH_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
